// File: rtl/core_mc.sv
// core_mc: multi-cycle accumulator core with a single req/ack memory port.
// Each instruction is fetched, executed, then optionally followed by one data transfer.
module core_mc #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int PC_STEP = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data_out,
    input  logic [DW-1:0] data_in,
    output logic          we,
    output logic          req,
    input  logic          ack,
    output logic          halted
);
    typedef enum logic [2:0] {START, FETCH, EXEC, MEM, HALT} state_t;
    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_acc;
    logic [DW-1:0] r_ir;
    logic [3:0]    w_op;
    logic [DW-1:0] w_imm;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] w_pc_next;
    logic [AW-1:0] w_target;
    assign w_op      = r_ir[DW-1:DW-4];
    assign w_imm     = {4'd0, r_ir[DW-5:0]};
    assign w_addr    = AW'(w_imm);
    assign w_pc_next = r_pc + AW'(PC_STEP);
    // Only consulted for JMP and BEQZ: JMP always takes the operand.
    assign w_target  = (w_op == 4'd5 || r_acc == '0) ? w_addr : w_pc_next;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= START;
            address  <= RESET_PC;
            data_out <= '0;
            we       <= 1'b0;
            req      <= 1'b0;
            halted   <= 1'b0;
            r_pc     <= RESET_PC;
            r_acc    <= '0;
            r_ir     <= '0;
        end else begin
            case (r_state)
                START: begin
                    req     <= 1'b1;
                    we      <= 1'b0;
                    address <= r_pc;
                    r_state <= FETCH;
                end
                FETCH: if (ack) begin
                    r_ir    <= data_in;
                    req     <= 1'b0;
                    r_state <= EXEC;
                end
                EXEC: case (w_op)
                    4'd1, 4'd3: begin
                        req     <= 1'b1;
                        address <= w_addr;
                        r_state <= MEM;
                    end
                    4'd2: begin
                        req      <= 1'b1;
                        we       <= 1'b1;
                        address  <= w_addr;
                        data_out <= r_acc;
                        r_state  <= MEM;
                    end
                    4'd5, 4'd6: begin
                        r_pc    <= w_target;
                        req     <= 1'b1;
                        address <= w_target;
                        r_state <= FETCH;
                    end
                    4'd7: begin
                        halted  <= 1'b1;
                        r_state <= HALT;
                    end
                    default: begin
                        r_acc   <= (w_op == 4'd4) ? r_acc + w_imm : r_acc;
                        r_pc    <= w_pc_next;
                        req     <= 1'b1;
                        address <= w_pc_next;
                        r_state <= FETCH;
                    end
                endcase
                // req stays high: the data transfer rolls straight into the next fetch.
                MEM: if (ack) begin
                    r_acc   <= (w_op == 4'd1) ? data_in : (w_op == 4'd3) ? r_acc + data_in : r_acc;
                    r_pc    <= w_pc_next;
                    we      <= 1'b0;
                    address <= w_pc_next;
                    r_state <= FETCH;
                end
                default: begin
                    req <= 1'b0;
                    we  <= 1'b0;
                end
            endcase
        end
    end
endmodule
